// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the post-commit store buffer: entry layout,
// drain FSM states, store funct3 encodings and the byte-enable mask function.
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 32;
    localparam int SB_DATA_W        = 32;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic                   valid;
        logic [SB_ADDR_W-1:2]   addr;
        logic [SB_DATA_W-1:0]   wdata;
        logic [3:0]             wmask;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE     = 2'd0,
        SB_ISSUE    = 2'd1,
        SB_WAIT_ACK = 2'd2
    } sb_state_t;

    // size is funct3[1:0] for both loads and stores (byte, half, word)
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << offset;
            2'b01:   m = 4'b0011 << {offset[1], 1'b0};
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Combinational youngest-first store-to-load match over the buffer entries.
// Reports a full-coverage hit with the entry's word data, or a partial-overlap stall.
module store_buffer_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t               entries_i [DEPTH],
    input  logic [PW-1:0]           tail_i,
    input  logic                    ld_valid_i,
    input  logic [SB_ADDR_W-1:2]    ld_word_i,
    input  logic [3:0]              ld_mask_i,
    output logic                    hit_o,
    output logic [SB_DATA_W-1:0]    data_o,
    output logic                    stall_o
);

    logic [DEPTH-1:0] overlap;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
            assign overlap[gi] = entries_i[gi].valid &&
                                 (entries_i[gi].addr == ld_word_i) &&
                                 (|(entries_i[gi].wmask & ld_mask_i));
        end
    endgenerate

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        hit_o   = 1'b0;
        stall_o = 1'b0;
        data_o  = '0;
        found   = 1'b0;
        idx     = '0;
        // Walk from tail-1 (youngest) back to tail (oldest when full); first overlap decides.
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail_i - PW'(i + 1);
            if (!found && overlap[idx]) begin
                found = 1'b1;
                if ((ld_mask_i & ~entries_i[idx].wmask) == 4'b0000) begin
                    hit_o  = 1'b1;
                    data_o = entries_i[idx].wdata;
                end else begin
                    stall_o = 1'b1;
                end
            end
        end
        if (!ld_valid_i) begin
            hit_o   = 1'b0;
            stall_o = 1'b0;
            data_o  = '0;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: FIFO of committed stores drained in order to the
// D-cache write port, with youngest-match forwarding lookup for the load unit.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int SB_DEPTH   = SB_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = SB_ADDR_W,
    parameter int DATA_WIDTH = SB_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        cache_stall,
    input  logic                        st_valid,
    input  logic [ADDR_WIDTH-1:0]       st_addr,
    input  logic [DATA_WIDTH-1:0]       st_data,
    input  logic [2:0]                  st_funct3,
    output logic                        st_ready,
    output logic                        dc_req_valid,
    output logic [ADDR_WIDTH-1:0]       dc_req_addr,
    output logic [DATA_WIDTH-1:0]       dc_req_wdata,
    output logic [3:0]                  dc_req_wmask,
    input  logic                        dc_req_ready,
    input  logic                        dc_resp_valid,
    input  logic                        ld_valid,
    input  logic [ADDR_WIDTH-1:0]       ld_addr,
    input  logic [2:0]                  ld_funct3,
    output logic                        ld_fwd_hit,
    output logic [DATA_WIDTH-1:0]       ld_fwd_data,
    output logic                        ld_fwd_stall,
    output logic                        sb_empty,
    output logic [$clog2(SB_DEPTH):0]   sb_count
);

    localparam int PW = $clog2(SB_DEPTH);

    sb_entry_t  entries_q [SB_DEPTH];
    sb_entry_t  new_entry;
    sb_entry_t  head_entry;
    sb_state_t  state_q, state_d;
    logic [PW:0] head_q, head_d, tail_q, tail_d, count;
    logic        full, push, pop;
    logic [3:0]  ld_mask;
    logic        unused_inputs;

    // Flush never touches committed stores; only the top funct3 bit of loads is irrelevant here.
    assign unused_inputs = ^{flush, ld_funct3[2]};

    assign count    = tail_q - head_q;
    assign full     = count[PW];
    assign sb_count = count;
    assign sb_empty = (count == '0);
    assign st_ready = !rst && !full;
    assign push     = st_valid && st_ready;
    assign pop      = (state_q == SB_WAIT_ACK) && dc_resp_valid;
    assign head_d   = head_q + {{PW{1'b0}}, pop};
    assign tail_d   = tail_q + {{PW{1'b0}}, push};

    always_comb begin
        new_entry.valid = 1'b1;
        new_entry.addr  = st_addr[ADDR_WIDTH-1:2];
        new_entry.wmask = byte_mask(st_funct3[1:0], st_addr[1:0]);
        case (st_funct3)
            F3_SB:   new_entry.wdata = {4{st_data[7:0]}};
            F3_SH:   new_entry.wdata = {2{st_data[15:0]}};
            F3_SW:   new_entry.wdata = st_data;
            default: new_entry.wdata = st_data;
        endcase
    end

    assign head_entry   = entries_q[head_q[PW-1:0]];
    assign dc_req_addr  = {head_entry.addr, 2'b00};
    assign dc_req_wdata = head_entry.wdata;
    assign dc_req_wmask = head_entry.wmask;

    always_comb begin
        state_d      = state_q;
        dc_req_valid = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (count != '0) state_d = SB_ISSUE;
            end
            SB_ISSUE: begin
                dc_req_valid = 1'b1;
                if (dc_req_ready && !cache_stall) state_d = SB_WAIT_ACK;
            end
            SB_WAIT_ACK: begin
                if (dc_resp_valid) state_d = (count != 1) ? SB_ISSUE : SB_IDLE;
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SB_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Push and pop never target the same slot: push needs !full, pop needs count!=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            if (push) entries_q[tail_q[PW-1:0]] <= new_entry;
            if (pop)  entries_q[head_q[PW-1:0]].valid <= 1'b0;
        end
    end

    assign ld_mask = byte_mask(ld_funct3[1:0], ld_addr[1:0]);

    store_buffer_fwd_match #(
        .DEPTH(SB_DEPTH)
    ) u_fwd_match (
        .entries_i  (entries_q),
        .tail_i     (tail_q[PW-1:0]),
        .ld_valid_i (ld_valid),
        .ld_word_i  (ld_addr[ADDR_WIDTH-1:2]),
        .ld_mask_i  (ld_mask),
        .hit_o      (ld_fwd_hit),
        .data_o     (ld_fwd_data),
        .stall_o    (ld_fwd_stall)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: expected drain requests and load lookups are queued
// by the stimulus and compared by a negedge monitor whenever the DUT presents them.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cache_stall = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [2:0]  st_funct3 = '0;
    logic        st_ready;
    logic        dc_req_valid;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic [3:0]  dc_req_wmask;
    logic        dc_req_ready = 1'b0;
    logic        dc_resp_valid = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_funct3 = '0;
    logic        ld_fwd_hit;
    logic [31:0] ld_fwd_data;
    logic        ld_fwd_stall;
    logic        sb_empty;
    logic [2:0]  sb_count;

    store_buffer dut (
        .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_ready(st_ready),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
        .dc_req_wmask(dc_req_wmask), .dc_req_ready(dc_req_ready), .dc_resp_valid(dc_resp_valid),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_fwd_stall(ld_fwd_stall),
        .sb_empty(sb_empty), .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } req_t;
    typedef struct { logic hit; logic stall; logic [31:0] data; } ld_t;

    req_t drain_q[$];
    ld_t  ld_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   resp_en = 1'b1;
    bit   pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted D-cache request and every load lookup.
    always @(negedge clk) begin
        req_t r;
        ld_t  l;
        if (!rst && dc_req_valid && dc_req_ready && !cache_stall) begin
            if (drain_q.size() == 0) begin
                check("unexpected dc_req", 32'(dc_req_valid), 32'd0);
            end else begin
                r = drain_q.pop_front();
                $display("drain: addr=0x%08h wdata=0x%08h mask=%b", dc_req_addr, dc_req_wdata, dc_req_wmask);
                check("dc_req_addr",  dc_req_addr,  r.addr);
                check("dc_req_wdata", dc_req_wdata, r.wdata);
                check("dc_req_wmask", 32'(dc_req_wmask), 32'(r.mask));
            end
        end
        if (ld_valid) begin
            if (ld_q.size() == 0) begin
                check("unexpected load", 32'(ld_valid), 32'd0);
            end else begin
                l = ld_q.pop_front();
                $display("load: addr=0x%08h f3=%b hit=%0d stall=%0d data=0x%08h",
                         ld_addr, ld_funct3, ld_fwd_hit, ld_fwd_stall, ld_fwd_data);
                check("ld_fwd_hit",   32'(ld_fwd_hit),   32'(l.hit));
                check("ld_fwd_stall", 32'(ld_fwd_stall), 32'(l.stall));
                check("ld_fwd_data",  ld_fwd_data,       l.data);
            end
        end
    end

    // D-cache model: one-cycle write-completion pulse after each accepted request.
    always @(negedge clk) begin
        if (rst) begin
            pending       = 1'b0;
            dc_resp_valid = 1'b0;
        end else begin
            dc_resp_valid = pending && resp_en;
            if (pending && resp_en) pending = 1'b0;
            if (dc_req_valid && dc_req_ready && !cache_stall) pending = 1'b1;
        end
    end

    task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
        req_t r;
        @(posedge clk); #1;
        st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
        check("st_ready at enqueue", 32'(st_ready), 32'd1);
        r.addr = {a[31:2], 2'b00}; r.wdata = exp_wdata; r.mask = exp_mask;
        drain_q.push_back(r);
        @(posedge clk); #1;
        st_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3,
                        input logic hit, input logic stall, input logic [31:0] data);
        ld_t l;
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3;
        l.hit = hit; l.stall = stall; l.data = data;
        ld_q.push_back(l);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while ((!sb_empty || drain_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, " sb_empty"}, 32'(sb_empty), 32'd1);
        check({name, " drained"}, 32'(drain_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst dc_req_valid", 32'(dc_req_valid), 32'd0);
        check("rst sb_empty",     32'(sb_empty),     32'd1);
        check("rst sb_count",     32'(sb_count),     32'd0);
        check("rst st_ready",     32'(st_ready),     32'd0);
        check("rst ld_fwd_hit",   32'(ld_fwd_hit),   32'd0);
        check("rst ld_fwd_stall", 32'(ld_fwd_stall), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post-rst st_ready", 32'(st_ready), 32'd1);

        // 1: single SW drains and buffer empties
        dc_req_ready = 1'b1;
        enq(32'h1000, 32'hDEADBEEF, 3'b010, 32'hDEADBEEF, 4'b1111);
        @(posedge clk); @(negedge clk);
        check("t1 dc_req_valid", 32'(dc_req_valid), 32'd1);
        check("t1 dc_req_addr",  dc_req_addr, 32'h1000);
        wait_empty("t1");

        // 2: fill with cache not ready, 5th store refused, then ordered drain
        dc_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            enq(32'h4000 + 32'(4 * i), 32'(i + 1), 3'b010, 32'(i + 1), 4'b1111);
        @(negedge clk);
        check("t2 sb_count full", 32'(sb_count), 32'd4);
        check("t2 st_ready full", 32'(st_ready), 32'd0);
        @(posedge clk); #1;
        st_valid = 1'b1; st_addr = 32'h5000; st_data = 32'h55555555; st_funct3 = 3'b010;
        @(posedge clk); #1 st_valid = 1'b0;
        @(negedge clk);
        check("t2 5th refused", 32'(sb_count), 32'd4);
        dc_req_ready = 1'b1;
        wait_empty("t2");

        // 3: byte store lane formatting and partial-overlap stall
        dc_req_ready = 1'b0;
        enq(32'h1003, 32'h000000AB, 3'b000, 32'hABABABAB, 4'b1000);
        load(32'h1003, 3'b100, 1'b1, 1'b0, 32'hABABABAB);
        load(32'h1000, 3'b010, 1'b0, 1'b1, 32'h0);
        load(32'h1002, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("t3 idle ld_fwd_hit",   32'(ld_fwd_hit),   32'd0);
        check("t3 idle ld_fwd_stall", 32'(ld_fwd_stall), 32'd0);
        dc_req_ready = 1'b1;
        wait_empty("t3");

        // 4: youngest of two matching stores wins
        dc_req_ready = 1'b0;
        enq(32'h2000, 32'h11111111, 3'b010, 32'h11111111, 4'b1111);
        enq(32'h2000, 32'h22222222, 3'b010, 32'h22222222, 4'b1111);
        load(32'h2000, 3'b010, 1'b1, 1'b0, 32'h22222222);
        load(32'h2002, 3'b101, 1'b1, 1'b0, 32'h22222222);
        dc_req_ready = 1'b1;
        wait_empty("t4");

        // 5: cache_stall holds ISSUE stable; flush mid-drain loses nothing
        cache_stall = 1'b1;
        enq(32'h3000, 32'hCAFEF00D, 3'b010, 32'hCAFEF00D, 4'b1111);
        enq(32'h3006, 32'h0000BEEF, 3'b001, 32'hBEEFBEEF, 4'b1100);
        k = 0;
        while (!dc_req_valid && k < 20) begin @(negedge clk); k++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5 stall dc_req_valid", 32'(dc_req_valid), 32'd1);
            check("t5 stall dc_req_addr",  dc_req_addr,  32'h3000);
            check("t5 stall dc_req_wdata", dc_req_wdata, 32'hCAFEF00D);
            check("t5 stall sb_count",     32'(sb_count), 32'd2);
        end
        @(posedge clk); #1;
        cache_stall = 1'b0;
        flush = 1'b1;
        repeat (3) @(posedge clk);
        #1 flush = 1'b0;
        wait_empty("t5");

        // 6: async reset while waiting for the write ack
        resp_en = 1'b0;
        dc_req_ready = 1'b0;
        enq(32'h6000, 32'h60606060, 3'b010, 32'h60606060, 4'b1111);
        enq(32'h6004, 32'h61616161, 3'b010, 32'h61616161, 4'b1111);
        enq(32'h6008, 32'h62626262, 3'b010, 32'h62626262, 4'b1111);
        dc_req_ready = 1'b1;
        k = 0;
        while (!dc_req_valid && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        check("t6 wait_ack dc_req_valid", 32'(dc_req_valid), 32'd0);
        check("t6 wait_ack sb_count",     32'(sb_count),     32'd3);
        rst = 1'b1;
        #1;
        check("t6 rst dc_req_valid", 32'(dc_req_valid), 32'd0);
        check("t6 rst sb_empty",     32'(sb_empty),     32'd1);
        check("t6 rst st_ready",     32'(st_ready),     32'd0);
        drain_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        resp_en = 1'b1;
        #1;
        check("t6 release st_ready", 32'(st_ready), 32'd1);
        check("t6 release sb_count", 32'(sb_count), 32'd0);
        enq(32'h7001, 32'h0000005A, 3'b000, 32'h5A5A5A5A, 4'b0010);
        wait_empty("t6 post-reset");

        repeat (3) @(negedge clk);
        check("leftover load expectations", 32'(ld_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
